// File: rtl/pipe_wb_ext.sv
// MEM/WB pipeline register: captures the MEM result bundle, forms the writeback
// word (ALU result or aligned, extended sub-word load) and counts retirements.
module pipe_wb_ext #(
  parameter int DW         = 32,
  parameter int RW         = 5,
  parameter int CW         = 32,
  parameter int ZERO_GUARD = 1
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      MEMvalid,
  input  logic                      MEMwreg,
  input  logic                      MEMm2reg,
  input  logic [RW-1:0]             MEMwn,
  input  logic [DW-1:0]             MEMaluResult,
  input  logic [DW-1:0]             MEMmemOut,
  input  logic [1:0]                MEMldsize,
  input  logic                      MEMldsign,
  input  logic [$clog2(DW/8)-1:0]   MEMbyteoff,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      WBvalid,
  output logic                      WBwreg,
  output logic [RW-1:0]             WBwn,
  output logic [DW-1:0]             WBdata,
  output logic [CW-1:0]             WBretired
);

  localparam int OFFW = $clog2(DW/8);

  logic            valid_q;
  logic            wreg_q;
  logic            m2reg_q;
  logic [RW-1:0]   wn_q;
  logic [DW-1:0]   alu_q;
  logic [DW-1:0]   mem_q;
  logic [1:0]      ldsize_q;
  logic            ldsign_q;
  logic [OFFW-1:0] byteoff_q;
  logic [CW-1:0]   retired_q;

  logic [OFFW-1:0] off_half;
  logic [OFFW-1:0] off_word;
  logic [DW-1:0]   shifted;
  logic [DW-1:0]   mask;
  logic [DW-1:0]   field;
  logic [DW-1:0]   extracted;
  logic            msb;

  // flush beats stall beats capture; flushed payload fields are simply held
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      wn_q      <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      ldsize_q  <= 2'b00;
      ldsign_q  <= 1'b0;
      byteoff_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end else if (!stall) begin
      valid_q   <= MEMvalid;
      wreg_q    <= MEMwreg;
      m2reg_q   <= MEMm2reg;
      wn_q      <= MEMwn;
      alu_q     <= MEMaluResult;
      mem_q     <= MEMmemOut;
      ldsize_q  <= MEMldsize;
      ldsign_q  <= MEMldsign;
      byteoff_q <= MEMbyteoff;
    end
  end

  // an instruction retires on the edge it leaves the slot
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      retired_q <= '0;
    end else if (valid_q && (!stall || flush)) begin
      retired_q <= retired_q + CW'(1);
    end
  end

  // unaligned half/word offsets are truncated down to the natural boundary
  assign off_half = byteoff_q & ~OFFW'(1);
  assign off_word = byteoff_q & ~OFFW'(3);

  always_comb begin
    shifted = mem_q;
    mask    = '1;
    msb     = mem_q[DW-1];
    case (ldsize_q)
      2'b01: begin
        shifted = mem_q >> {off_half, 3'b000};
        mask    = DW'(16'hFFFF);
        msb     = shifted[15];
      end
      2'b10: begin
        shifted = mem_q >> {byteoff_q, 3'b000};
        mask    = DW'(8'hFF);
        msb     = shifted[7];
      end
      2'b11: begin
        shifted = mem_q >> {off_word, 3'b000};
        mask    = DW'(32'hFFFF_FFFF);
        msb     = shifted[31];
      end
      default: begin
        shifted = mem_q;
        mask    = '1;
        msb     = mem_q[DW-1];
      end
    endcase
    field     = shifted & mask;
    extracted = (ldsign_q && msb) ? (field | ~mask) : field;
  end

  assign WBvalid   = valid_q;
  assign WBwreg    = valid_q & wreg_q & ((ZERO_GUARD == 0) || (wn_q != '0));
  assign WBwn      = wn_q;
  assign WBdata    = m2reg_q ? extracted : alu_q;
  assign WBretired = retired_q;

endmodule

// File: tb/tb_pipe_wb_ext.sv
// Bench for pipe_wb_ext: a 32-bit guarded instance and a 64-bit unguarded one
// share stimulus and are compared every cycle against a slot-level model.
module tb_pipe_wb_ext;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        mvalid = 1'b0, mwreg = 1'b0, mm2reg = 1'b0, msign = 1'b0;
  logic [4:0]  mwn = '0;
  logic [63:0] malu = '0, mmem = '0;
  logic [1:0]  msize = '0;
  logic [2:0]  moff = '0;
  logic        stall = 1'b0, flush = 1'b0;

  logic        a_valid, a_wreg, b_valid, b_wreg;
  logic [4:0]  a_wn, b_wn;
  logic [31:0] a_data;
  logic [63:0] b_data;
  logic [3:0]  a_ret;
  logic [15:0] b_ret;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_wb_ext #(.DW(32), .RW(5), .CW(4), .ZERO_GUARD(1)) dut_a (
    .clk(clk), .clrn(clrn), .MEMvalid(mvalid), .MEMwreg(mwreg), .MEMm2reg(mm2reg),
    .MEMwn(mwn), .MEMaluResult(malu[31:0]), .MEMmemOut(mmem[31:0]), .MEMldsize(msize),
    .MEMldsign(msign), .MEMbyteoff(moff[1:0]), .stall(stall), .flush(flush),
    .WBvalid(a_valid), .WBwreg(a_wreg), .WBwn(a_wn), .WBdata(a_data), .WBretired(a_ret));

  pipe_wb_ext #(.DW(64), .RW(5), .CW(16), .ZERO_GUARD(0)) dut_b (
    .clk(clk), .clrn(clrn), .MEMvalid(mvalid), .MEMwreg(mwreg), .MEMm2reg(mm2reg),
    .MEMwn(mwn), .MEMaluResult(malu), .MEMmemOut(mmem), .MEMldsize(msize),
    .MEMldsign(msign), .MEMbyteoff(moff), .stall(stall), .flush(flush),
    .WBvalid(b_valid), .WBwreg(b_wreg), .WBwn(b_wn), .WBdata(b_data), .WBretired(b_ret));

  typedef struct {
    bit        valid, wreg, m2reg, sign;
    bit [4:0]  wn;
    bit [63:0] alu, mem;
    bit [1:0]  size;
    bit [2:0]  off;
  } slot_t;

  slot_t       m;
  int unsigned ret = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // writeback word computed from the load rules with plain arithmetic
  function automatic logic [63:0] exp_data(input slot_t s, input int dw);
    longint unsigned mem, fld, lo;
    int w, boff;
    mem  = (dw == 32) ? (s.mem & 64'hFFFF_FFFF) : s.mem;
    boff = (dw == 32) ? int'(s.off) % 4 : int'(s.off);
    if (!s.m2reg) return (dw == 32) ? (s.alu & 64'hFFFF_FFFF) : s.alu;
    case (s.size)
      2'd2: w = 8;
      2'd1: begin w = 16; boff = boff - boff % 2; end
      2'd3: begin w = 32; boff = boff - boff % 4; end
      default: begin w = dw; boff = 0; end
    endcase
    fld = mem >> (8 * boff);
    if (w < 64) begin
      lo  = (64'd1 << w) - 1;
      fld = fld & lo;
      if (s.sign && fld[w-1]) fld = fld | ~lo;
    end
    if (dw == 32) fld = fld & 64'hFFFF_FFFF;
    return fld;
  endfunction

  // slot model: async clear, otherwise flush > stall > capture
  initial forever begin
    @(posedge clk or negedge clrn);
    if (!clrn) begin
      m   = '{default: 0};
      ret = 0;
    end else begin
      if (m.valid && (!stall || flush)) ret++;
      if (flush) begin
        m.valid = 0;
        m.wreg  = 0;
      end else if (!stall) begin
        m.valid = mvalid; m.wreg = mwreg; m.m2reg = mm2reg; m.wn = mwn;
        m.alu = malu; m.mem = mmem; m.size = msize; m.sign = msign; m.off = moff;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("a_valid", 64'(a_valid), 64'(m.valid));
    check("a_wreg", 64'(a_wreg), 64'(m.valid && m.wreg && m.wn != 0));
    check("a_wn", 64'(a_wn), 64'(m.wn));
    check("a_data", 64'(a_data), exp_data(m, 32));
    check("a_ret", 64'(a_ret), 64'(ret % 16));
    check("b_valid", 64'(b_valid), 64'(m.valid));
    check("b_wreg", 64'(b_wreg), 64'(m.valid && m.wreg));
    check("b_wn", 64'(b_wn), 64'(m.wn));
    check("b_data", b_data, exp_data(m, 64));
    check("b_ret", 64'(b_ret), 64'(ret % 65536));
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input bit w, input bit m2, input bit [4:0] n,
                     input bit [63:0] a, input bit [63:0] mm, input bit [1:0] sz,
                     input bit sg, input bit [2:0] o);
    mvalid = v; mwreg = w; mm2reg = m2; mwn = n;
    malu = a; mmem = mm; msize = sz; msign = sg; moff = o;
  endtask

  task automatic rnd_in;
    put(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
        {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
        1'($urandom), 3'($urandom));
  endtask

  task automatic do_reset;
    clrn = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    repeat (3) begin
      rnd_in();
      step();
      check("rst_a_valid", 64'(a_valid), 64'd0);
      check("rst_a_data", 64'(a_data), 64'd0);
      check("rst_b_data", b_data, 64'd0);
      check("rst_b_ret", 64'(b_ret), 64'd0);
    end
    clrn = 1'b1;
  endtask

  int unsigned rr;

  initial begin
    do_reset();
    put(1, 1, 0, 7, 64'h1234_5678, 64'h0, 2'b00, 0, 0);
    step();
    check("first_wreg", 64'(a_wreg), 64'd1);
    check("first_wn", 64'(a_wn), 64'd7);
    check("first_data", 64'(a_data), 64'h1234_5678);
    check("first_ret0", 64'(a_ret), 64'd0);
    put(0, 0, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0);
    step();
    check("first_ret1", 64'(a_ret), 64'd1);

    put(1, 1, 1, 3, 64'h0, 64'h80FF_1234, 2'b10, 1, 3);
    step(); check("ld_byte_s3", 64'(a_data), 64'hFFFF_FF80);
    put(1, 1, 1, 3, 64'h0, 64'h80FF_1234, 2'b10, 0, 0);
    step(); check("ld_byte_u0", 64'(a_data), 64'h0000_0034);
    put(1, 1, 1, 3, 64'h0, 64'h80FF_1234, 2'b01, 1, 2);
    step(); check("ld_half_s2", 64'(a_data), 64'hFFFF_80FF);
    put(1, 1, 1, 3, 64'h0, 64'h80FF_1234, 2'b01, 0, 1);
    step(); check("ld_half_u1", 64'(a_data), 64'h0000_1234);
    put(1, 1, 1, 3, 64'h0, 64'h8000_0001_7FFF_FFFF, 2'b11, 1, 4);
    step(); check("ld64_word4", b_data, 64'hFFFF_FFFF_8000_0001);
    put(1, 1, 1, 3, 64'h0, 64'h8000_0001_7FFF_FFFF, 2'b11, 1, 0);
    step(); check("ld64_word0", b_data, 64'h0000_0000_7FFF_FFFF);

    put(1, 1, 0, 0, 64'h55, 64'h0, 2'b00, 0, 0);
    step();
    check("zg_a_wreg", 64'(a_wreg), 64'd0);
    check("zg_a_valid", 64'(a_valid), 64'd1);
    check("zg_b_wreg", 64'(b_wreg), 64'd1);
    rr = ret;
    put(0, 0, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0);
    step();
    check("zg_ret", 64'(a_ret), 64'((rr + 1) % 16));

    put(1, 1, 0, 9, 64'hCAFE_F00D, 64'h0, 2'b00, 0, 0);
    step();
    rr = ret;
    stall = 1'b1;
    repeat (3) begin
      rnd_in();
      step();
      check("stall_data", 64'(a_data), 64'hCAFE_F00D);
      check("stall_wn", 64'(a_wn), 64'd9);
      check("stall_ret", 64'(a_ret), 64'(rr % 16));
    end
    stall = 1'b0;
    put(0, 0, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0);
    step();
    check("unstall_ret", 64'(a_ret), 64'((rr + 1) % 16));
    check("unstall_valid", 64'(a_valid), 64'd0);

    put(1, 1, 0, 4, 64'hBEEF, 64'h0, 2'b00, 0, 0);
    step();
    rr = ret;
    stall = 1'b1;
    flush = 1'b1;
    rnd_in();
    step();
    check("flush_valid", 64'(a_valid), 64'd0);
    check("flush_wreg", 64'(a_wreg), 64'd0);
    check("flush_ret", 64'(a_ret), 64'((rr + 1) % 16));
    stall = 1'b0;
    flush = 1'b0;

    do_reset();
    repeat (17) begin
      rnd_in();
      mvalid = 1'b1;
      step();
    end
    put(0, 0, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0);
    step();
    check("wrap_a_ret", 64'(a_ret), 64'd1);
    check("wrap_b_ret", 64'(b_ret), 64'd17);

    for (int i = 0; i < 3000; i++) begin
      rnd_in();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      clrn  = ($urandom_range(0, 199) != 0);
      step();
    end
    clrn = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
